// File: rtl/if_stage_fetch.sv
// rtl/if_stage_fetch.sv - instruction fetch stage with credit-limited requests, drop counting and decode FIFO
module if_stage_fetch #(
  parameter int ADDRESS_LEN     = 32,
  parameter int INSTRUCTION_LEN = 32,
  parameter int DEPTH           = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic                       branch_taken,
  input  logic [ADDRESS_LEN-1:0]     branch_addr,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [ADDRESS_LEN-1:0]     imem_req_addr,
  input  logic                       imem_resp_valid,
  input  logic [INSTRUCTION_LEN-1:0] imem_resp_data,
  output logic                       inst_valid,
  output logic [INSTRUCTION_LEN-1:0] instruction,
  output logic [ADDRESS_LEN-1:0]     pc_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDRESS_LEN-1:0]     fetch_pc;
  logic [CW-1:0]              outstanding;
  logic [CW-1:0]              outstanding_next;
  logic [CW-1:0]              drop_cnt;
  logic [CW-1:0]              count;
  logic [CW:0]                credit_used;

  logic [ADDRESS_LEN-1:0]     pc_queue [DEPTH];
  logic [PW-1:0]              pcq_wr;
  logic [PW-1:0]              pcq_rd;

  logic [ADDRESS_LEN-1:0]     fifo_pc   [DEPTH];
  logic [INSTRUCTION_LEN-1:0] fifo_data [DEPTH];
  logic [PW-1:0]              fifo_wr;
  logic [PW-1:0]              fifo_rd;

  logic req_fire;
  logic resp_fire;
  logic discard;
  logic push;
  logic pop;
  logic unused_addr_bits;

  // Credits cover both in-flight requests and buffered entries, so a push never meets a full FIFO.
  assign credit_used      = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid   = rst & ~branch_taken & (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr    = fetch_pc;
  assign req_fire         = imem_req_valid & imem_req_ready;
  assign resp_fire        = imem_resp_valid & (outstanding != '0);
  assign discard          = (drop_cnt != '0) | branch_taken;
  assign push             = resp_fire & ~discard;
  assign outstanding_next = outstanding + CW'(req_fire) - CW'(resp_fire);

  assign inst_valid  = rst & (count != '0);
  assign pop         = inst_valid & ~freeze & ~branch_taken;
  assign instruction = inst_valid ? fifo_data[fifo_rd] : '0;
  assign pc_out      = inst_valid ? fifo_pc[fifo_rd] + ADDRESS_LEN'(4) : '0;

  assign unused_addr_bits = ^branch_addr[1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (req_fire) pcq_wr <= pcq_wr + PW'(1);
      if (resp_fire) pcq_rd <= pcq_rd + PW'(1);
      if (branch_taken) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc <= {branch_addr[ADDRESS_LEN-1:2], 2'b00};
        drop_cnt <= outstanding_next;
        count    <= '0;
        fifo_wr  <= '0;
        fifo_rd  <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + ADDRESS_LEN'(4);
        if (resp_fire && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (push) fifo_wr <= fifo_wr + PW'(1);
        if (pop) fifo_rd <= fifo_rd + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pc_queue[pcq_wr] <= fetch_pc;
    if (push) begin
      fifo_pc[fifo_wr]   <= pc_queue[pcq_rd];
      fifo_data[fifo_wr] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_if_stage_fetch.sv
// tb/tb_if_stage_fetch.sv - phase-table bench with memory model and decode scoreboard for if_stage_fetch
module tb_if_stage_fetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [31:0] pc_out;

  if_stage_fetch #(.ADDRESS_LEN(32), .INSTRUCTION_LEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .instruction(instruction), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          drop;
  } flight_t;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int          n;
    bit          r;
    bit          f;
    bit          b;
    logic [31:0] ba;
    bit          rdy;
    int          lat;
    int          wait_infl;
    bit          wait_resp;
    bit          junk;
    bit          chk;
    logic [31:0] exp_addr;
  } vec_t;

  flight_t     inflight[$];
  exp_t        sb[$];
  vec_t        tbl[13];
  logic [31:0] exp_fetch = '0;
  int          cycle = 0;
  int          lat = 1;
  bit          junk = 1'b0;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'hE000_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cycle, act, req);
    end
  endtask

  task automatic step(input bit r, input bit f, input bit b, input logic [31:0] ba, input bit rdy);
    bit      exp_req;
    bit      exp_iv;
    flight_t fl;
    rst = r; freeze = f; branch_taken = b; branch_addr = ba; imem_req_ready = rdy;
    if (junk) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hDEAD_BEEF;
    end else if (inflight.size() > 0 && inflight[0].due <= cycle) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(inflight[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    @(negedge clk);
    exp_req = r && !b && (inflight.size() + sb.size() < DEPTH);
    exp_iv  = r && (sb.size() != 0);
    check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
    if (exp_req) check("req_addr", imem_req_addr, exp_fetch);
    check("inst_valid", {31'b0, inst_valid}, {31'b0, exp_iv});
    if (exp_iv) begin
      check("instruction", instruction, sb[0].data);
      check("pc_out", pc_out, sb[0].pc4);
    end else begin
      check("instruction_zero", instruction, 32'h0);
      check("pc_out_zero", pc_out, 32'h0);
    end
    if (!r) begin
      inflight.delete();
      sb.delete();
      exp_fetch = '0;
    end else begin
      if (exp_iv && !f && !b) void'(sb.pop_front());
      if (imem_resp_valid && inflight.size() > 0) begin
        fl = inflight.pop_front();
        if (!fl.drop && !b) sb.push_back('{pc4: fl.addr + 32'd4, data: imem_resp_data});
      end
      if (b) begin
        sb.delete();
        foreach (inflight[i]) inflight[i].drop = 1'b1;
        exp_fetch = {ba[31:2], 2'b00};
      end else if (exp_req && rdy) begin
        inflight.push_back('{addr: exp_fetch, due: cycle + lat, drop: 1'b0});
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  initial begin
    //        n   r  f  b  ba            rdy lat wi wr junk chk exp_addr
    tbl[0]  = '{2,  0, 0, 0, 32'h0,      1,  1,  0, 0, 0,   1,  32'h0};
    tbl[1]  = '{12, 1, 0, 0, 32'h0,      1,  1,  0, 0, 0,   0,  32'h0};
    tbl[2]  = '{5,  1, 1, 0, 32'h0,      1,  1,  0, 0, 0,   0,  32'h0};
    tbl[3]  = '{4,  1, 0, 0, 32'h0,      1,  1,  0, 0, 0,   0,  32'h0};
    tbl[4]  = '{1,  1, 0, 1, 32'h100,    1,  3,  2, 0, 0,   1,  32'h100};
    tbl[5]  = '{10, 1, 0, 0, 32'h0,      1,  3,  0, 0, 0,   0,  32'h0};
    tbl[6]  = '{1,  1, 1, 1, 32'h203,    1,  3,  0, 1, 0,   1,  32'h200};
    tbl[7]  = '{6,  1, 0, 0, 32'h0,      1,  1,  0, 0, 0,   0,  32'h0};
    tbl[8]  = '{4,  1, 0, 0, 32'h0,      0,  1,  0, 0, 0,   0,  32'h0};
    tbl[9]  = '{4,  1, 0, 0, 32'h0,      1,  1,  0, 0, 0,   0,  32'h0};
    tbl[10] = '{1,  0, 0, 0, 32'h0,      1,  3,  2, 0, 1,   1,  32'h0};
    tbl[11] = '{1,  1, 0, 0, 32'h0,      1,  3,  0, 0, 1,   0,  32'h0};
    tbl[12] = '{10, 1, 0, 0, 32'h0,      1,  1,  0, 0, 0,   0,  32'h0};

    @(posedge clk);
    #1;
    for (int p = 0; p < 13; p++) begin
      int guard;
      lat = tbl[p].lat;
      guard = 0;
      while ((inflight.size() < tbl[p].wait_infl ||
              (tbl[p].wait_resp && !(inflight.size() > 0 && inflight[0].due <= cycle))) && guard < 20) begin
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        guard++;
      end
      if (guard >= 20) begin
        errors++;
        checks++;
        $display("FAIL phase_wait phase=%0d inflight=%0d timed out", p, inflight.size());
      end
      junk = tbl[p].junk;
      for (int k = 0; k < tbl[p].n; k++)
        step(tbl[p].r, tbl[p].f, tbl[p].b, tbl[p].ba, tbl[p].rdy);
      junk = 1'b0;
      if (tbl[p].chk) check("phase_addr", imem_req_addr, tbl[p].exp_addr);
    end

    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage_fetch.md
Name: if_stage_fetch

Overview:
- Instruction-fetch stage; sits directly upstream of the decode stage.
- Owns the fetch PC and issues in-order requests to instruction memory over a valid/ready request channel. Responses come back on a valid-only channel.
- Buffers returned instructions in a small FIFO and presents them to decode with their PC+4.
- Handles decode stall (freeze) and taken-branch redirect, including discarding responses that are still in flight when a redirect occurs.

Parameters:
- ADDRESS_LEN, 32, width of PC and memory address.
- INSTRUCTION_LEN, 32, instruction width.
- DEPTH, 2, FIFO depth and maximum number of requests in flight plus buffered; power of two, at least 2.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset.
- freeze  input  1  decode stall (hazard); head entry is not consumed.
- branch_taken  input  1  redirect request from execute.
- branch_addr  input  ADDRESS_LEN  redirect target.
- imem_req_valid  output  1  request present.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  ADDRESS_LEN  word-aligned fetch address.
- imem_resp_valid  input  1  response data valid; responses are in order, at least 1 cycle after the request is accepted.
- imem_resp_data  input  INSTRUCTION_LEN  returned instruction.
- inst_valid  output  1  FIFO head valid.
- instruction  output  INSTRUCTION_LEN  FIFO head data; 0 when the FIFO is empty.
- pc_out  output  ADDRESS_LEN  head PC + 4; 0 when the FIFO is empty.

Behaviour:
- Reset (rst=0 at the edge), applies even mid-operation:
  - fetch_pc=0, outstanding=0, drop_cnt=0, FIFO empty.
  - Outputs: imem_req_valid=0 for that cycle, inst_valid=0, instruction=0, pc_out=0.
  - Any response arriving after reset with outstanding=0 is ignored.
- State: fetch_pc; outstanding (accepted requests awaiting a response, 0..DEPTH); drop_cnt (responses still to discard, never more than outstanding); PC queue of issued addresses; data FIFO of {pc, instr} with count 0..DEPTH.
- Request issue:
  - imem_req_valid = rst & ~branch_taken & (outstanding + count < DEPTH).
  - imem_req_addr = fetch_pc.
  - req_fire = valid & ready. On req_fire: fetch_pc += 4 (wraps modulo 2^ADDRESS_LEN) and the address is pushed to the PC queue.
  - imem_req_valid must stay asserted with a stable address until accepted, unless branch_taken or reset.
- Response, resp_fire = imem_resp_valid & (outstanding > 0):
  - Pops the PC queue and decrements outstanding.
  - If drop_cnt > 0 or branch_taken: the response is discarded and drop_cnt decrements (only when it was > 0).
  - Otherwise: {queued pc, data} is pushed to the FIFO.
- Decode handshake:
  - pop = inst_valid & ~freeze & ~branch_taken.
  - Outputs are combinational from the FIFO head; 1-cycle minimum latency from response to inst_valid.
  - Push and pop in the same cycle are allowed. Push into a full FIFO cannot occur because of the credit rule.
- Redirect (branch_taken=1); has priority over freeze and over normal issue:
  - fetch_pc <= {branch_addr[ADDRESS_LEN-1:2], 2'b00}.
  - FIFO cleared. A response arriving that cycle is discarded.
  - drop_cnt <= outstanding_next, where outstanding_next = outstanding - resp_fire; no request fires in a branch cycle.
  - inst_valid=0 from the next cycle until the first post-redirect response arrives.
- freeze=1 with branch_taken=0: FIFO head held; outputs stable. Issue continues while credit is available.
- Invariant: outstanding + count <= DEPTH at all times.

Test Plan:
- Sequential fetch, zero-wait memory (ready=1, 1-cycle response, data=addr|0xE000_0000): inst_valid=1 from cycle 2; pc_out steps 4,8,12,...; no gaps.
- freeze held 3 cycles with the FIFO full (DEPTH=2): imem_req_valid=0; head instruction/pc_out unchanged; after release, the next entry appears the following cycle with no loss or duplication.
- Branch to 0x100 with 2 requests outstanding (3-cycle response latency): next 2 responses discarded; first inst_valid has pc_out=0x104 and instruction=mem[0x100]; imem_req_addr=0x100 on the cycle after the branch.
- Branch in the same cycle as a response and with freeze=1, branch_addr=0x203: response discarded; fetch_pc=0x200; FIFO empty next cycle.
- Reset (rst=0) asserted mid-stream with 2 outstanding, released after 1 cycle: outputs zero; the late responses are ignored; fetch restarts at addr 0.
- imem_req_ready low for 4 cycles: imem_req_addr held stable; fetch_pc advances only on the accept cycle.
